ob_result_capture: RTL and testbench
====================================

Name: ob_result_capture

Overview:
- Receive-side counterpart of the array's external result driver.
- Collects DRIVER_WIDTH-wide beats from ext_result/ext_valid and assembles them into full COL*WIDTH output rows.
- Writes each row into the output-buffer SRAM through the active-low cenb/wenb memory port.
- Used in system integration and in the bench to rebuild the output matrix from the serial result stream.

Parameters:
- WIDTH, 16, element width in bits.
- COL, 4, elements per output row.
- DRIVER_WIDTH, 16, beat width; COL*WIDTH must be an integer multiple of it.
- O_SIZE, 256, output-buffer depth in rows; power of two.

Ports:
- clk_i  in  1  clock.
- rst_async_i  in  1  asynchronous active-high reset.
- start_i  in  1  one-cycle pulse that arms a capture.
- base_addr_i  in  $clog2(O_SIZE)  first row address; sampled on start_i.
- stop_code_i  in  DRIVER_WIDTH  end-of-stream code; sampled on start_i.
- ext_result_i  in  DRIVER_WIDTH  result beat.
- ext_valid_i  in  1  beat qualifier.
- mem_cenb_o  out  1  memory chip enable, active low.
- mem_wenb_o  out  1  memory write enable, active low.
- mem_addr_o  out  $clog2(O_SIZE)  memory row address.
- mem_d_o  out  COL*WIDTH  memory write data.
- rows_o  out  $clog2(O_SIZE)+1  rows written in the current capture.
- busy_o  out  1  high while capturing.
- done_o  out  1  sticky end-of-capture flag.
- overflow_o  out  1  sticky address-wrap flag.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - mem_cenb_o=1, mem_wenb_o=1; mem_addr_o, mem_d_o and rows_o clear to 0.
  - busy_o, done_o and overflow_o clear to 0.
  - Beat counter and assembler clear.
- Derived constant: CHUNKS = COL*WIDTH/DRIVER_WIDTH (4 at the defaults).
- States: IDLE, CAPTURE, DONE.
- IDLE:
  - Beats are ignored.
  - start_i latches base_addr_i and stop_code_i, clears rows_o, done_o and overflow_o, and moves to CAPTURE.
- CAPTURE:
  - busy_o=1.
  - Each cycle with ext_valid_i=1 accepts one beat.
  - Beat k (k=0..CHUNKS-1) fills assembler bits [k*DRIVER_WIDTH +: DRIVER_WIDTH], so the first beat lands in the LSBs.
- Row write:
  - Triggered by acceptance of beat CHUNKS-1.
  - On the next clock edge: mem_cenb_o=0, mem_wenb_o=0, mem_addr_o=(base+rows_o) mod O_SIZE, mem_d_o=assembled row. These hold for exactly one cycle.
  - rows_o increments on that same edge.
  - Write latency is 1 cycle after the last beat.
  - A beat accepted in the write cycle is loaded into a fresh assembler. Back-to-back rows never stall.
- Stop code:
  - ext_valid_i=1 with ext_result_i==stop_code is recognised only at a row boundary (beat counter = 0).
  - That beat is consumed and not written; next state is DONE.
  - Mid-row, a beat equal to the stop code is ordinary data.
- DONE:
  - busy_o=0; done_o=1, held until the next start_i.
  - A pending row write, if any, completes in the cycle the stop beat is accepted.
  - start_i re-arms directly into CAPTURE.
- start_i during CAPTURE is ignored.
- Wrap: the address is computed mod O_SIZE. When rows_o reaches O_SIZE, the write still occurs at the wrapped address, overflow_o is set (sticky until start_i), and rows_o saturates at O_SIZE.
- Partial row when stopped: none can exist, because stop is only recognised at a row boundary.
- When mem_cenb_o=1, mem_d_o holds its last value.

Optional Feature:
- Macro: OB_RESULT_CAPTURE_CHECKSUM_EN.
- When defined:
  - Adds output checksum_o, COL*WIDTH bits wide.
  - checksum_o is the running XOR of every written row.
  - It clears on start_i and on reset, and updates in the same cycle as the write.
- When undefined: no checksum_o port and no checksum logic.

Decomposition:
- Shared package (matrix_mult_pkg):
  - Typedef cap_state_e {IDLE, CAPTURE, DONE}.
  - Function chunks(COL, WIDTH, DRIVER_WIDTH).
  - Elaboration-time assertion on the divisibility rule.
- Sub-module ob_chunk_assembler: beat counter plus indexed-fill register, outputs row_valid and row_data. The FSM and memory-port logic stay in the top.

Test Plan:
- Single row: base=0x10, stop=0xFFFF; beats 0x0001,0x0002,0x0003,0x0004 then 0xFFFF -> one write at addr 0x10, data 0x0004_0003_0002_0001, one cycle after beat 4; done_o=1; rows_o=1.
- Back-to-back streaming: 8 rows, ext_valid_i held high for 32 cycles -> 8 single-cycle writes at 0x10..0x17 spaced 4 cycles apart; no dropped beats.
- Mid-row stop code: beats 0xAAAA,0xFFFF,0xBBBB,0xCCCC, then 0xFFFF -> row 0xCCCC_BBBB_FFFF_AAAA written; done_o asserted only after the second 0xFFFF.
- Wrap: base=0xFE, 3 rows -> writes to 0xFE, 0xFF, 0x00; overflow_o=0. With base=0 and 257 rows -> overflow_o=1 and rows_o=256.
- Reset mid-capture: assert rst_async_i after beat 2 of a row -> no write; all outputs at reset values. After re-arm, a full row lands at the newly sampled base.
- Idle/gaps: ext_valid_i toggling 1-0-1-0 -> beats are accepted only when valid and assembly is correct; beats sent in IDLE produce no writes.

Source files
------------

// File: rtl/matrix_mult_pkg.sv
// Shared types and helpers for the matrix-multiply result path.
//   cap_state_e  : capture FSM states (IDLE, CAPTURE, DONE)
//   chunks()     : number of driver beats per output row
//   chunks_exact(): true when a row is a whole number of beats
package matrix_mult_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } cap_state_e;

    function automatic int unsigned chunks(input int unsigned col,
                                           input int unsigned width,
                                           input int unsigned driver_width);
        return (col * width) / driver_width;
    endfunction

    function automatic bit chunks_exact(input int unsigned col,
                                        input int unsigned width,
                                        input int unsigned driver_width);
        return ((col * width) % driver_width) == 0;
    endfunction

endpackage

// File: rtl/ob_chunk_assembler.sv
// Beat-to-row assembler: fills a ROW_W-wide register one DRIVER_WIDTH beat at
// a time, first beat in the LSBs.
//   clk_i, rst_async_i : clock, asynchronous active-high reset
//   clear_i            : drop any partial row and restart at beat 0
//   load_i, beat_i     : accept one beat
//   at_boundary_o      : beat counter is 0 (no partial row held)
//   row_valid_o        : the beat being loaded completes a row (combinational)
//   row_data_o         : full row including the beat being loaded
module ob_chunk_assembler #(
    parameter int unsigned ROW_W        = 64,
    parameter int unsigned DRIVER_WIDTH = 16,
    parameter int unsigned CHUNKS       = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_async_i,
    input  logic                    clear_i,
    input  logic                    load_i,
    input  logic [DRIVER_WIDTH-1:0] beat_i,
    output logic                    at_boundary_o,
    output logic                    row_valid_o,
    output logic [ROW_W-1:0]        row_data_o
);

    localparam int unsigned CW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(CHUNKS - 1);

    logic [CW-1:0]    cnt_q;
    logic [ROW_W-1:0] fill_q;
    logic [ROW_W-1:0] merged;

    // Current beat merged into its slot so the completed row is available in
    // the same cycle the last beat is accepted.
    always_comb begin
        merged = fill_q;
        for (int unsigned k = 0; k < CHUNKS; k++) begin
            if (cnt_q == CW'(k)) begin
                merged[k*DRIVER_WIDTH +: DRIVER_WIDTH] = beat_i;
            end
        end
    end

    assign at_boundary_o = (cnt_q == '0);
    assign row_valid_o   = load_i && (cnt_q == LAST);
    assign row_data_o    = merged;

    always_ff @(posedge clk_i or posedge rst_async_i) begin
        if (rst_async_i) begin
            cnt_q  <= '0;
            fill_q <= '0;
        end else if (clear_i) begin
            cnt_q  <= '0;
            fill_q <= '0;
        end else if (load_i) begin
            if (cnt_q == LAST) begin
                cnt_q  <= '0;
                fill_q <= '0;
            end else begin
                cnt_q  <= cnt_q + 1'b1;
                fill_q <= merged;
            end
        end
    end

endmodule

// File: rtl/ob_result_capture.sv
// Output-buffer result capture: rebuilds COL*WIDTH rows from the serial
// DRIVER_WIDTH result stream and writes each row to the output-buffer SRAM
// through an active-low cenb/wenb port.
//   clk_i, rst_async_i       : clock, asynchronous active-high reset
//   start_i                  : arm a capture (samples base_addr_i, stop_code_i)
//   ext_result_i/ext_valid_i : result beat stream
//   mem_cenb_o/mem_wenb_o    : one-cycle active-low write strobe
//   mem_addr_o/mem_d_o       : write address (base+row mod O_SIZE) and data
//   rows_o                   : rows written this capture (saturates at O_SIZE)
//   busy_o/done_o/overflow_o : capturing, sticky done, sticky address wrap
// Optional: define OB_RESULT_CAPTURE_CHECKSUM_EN to add checksum_o, the
// running XOR of every written row.
module ob_result_capture
    import matrix_mult_pkg::*;
#(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned COL          = 4,
    parameter int unsigned DRIVER_WIDTH = 16,
    parameter int unsigned O_SIZE       = 256
) (
    input  logic                       clk_i,
    input  logic                       rst_async_i,
    input  logic                       start_i,
    input  logic [$clog2(O_SIZE)-1:0]  base_addr_i,
    input  logic [DRIVER_WIDTH-1:0]    stop_code_i,
    input  logic [DRIVER_WIDTH-1:0]    ext_result_i,
    input  logic                       ext_valid_i,
    output logic                       mem_cenb_o,
    output logic                       mem_wenb_o,
    output logic [$clog2(O_SIZE)-1:0]  mem_addr_o,
    output logic [COL*WIDTH-1:0]       mem_d_o,
    output logic [$clog2(O_SIZE):0]    rows_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       overflow_o
`ifdef OB_RESULT_CAPTURE_CHECKSUM_EN
    ,
    output logic [COL*WIDTH-1:0]       checksum_o
`endif
);

    localparam int unsigned AW     = $clog2(O_SIZE);
    localparam int unsigned ROW_W  = COL * WIDTH;
    localparam int unsigned CHUNKS = chunks(COL, WIDTH, DRIVER_WIDTH);
    localparam logic [AW:0] ROWS_MAX = (AW+1)'(O_SIZE);

    if (!chunks_exact(COL, WIDTH, DRIVER_WIDTH)) begin : g_bad_chunks
        $error("COL*WIDTH must be a multiple of DRIVER_WIDTH");
    end

    cap_state_e              state_q;
    logic [AW-1:0]           base_q;
    logic [DRIVER_WIDTH-1:0] stop_q;

    logic             accept;
    logic             stop_hit;
    logic             load;
    logic             asm_clear;
    logic             at_boundary;
    logic             row_valid;
    logic [ROW_W-1:0] row_data;

    assign accept    = (state_q == CAPTURE) && ext_valid_i;
    // Stop code only counts between rows; mid-row it is plain data.
    assign stop_hit  = accept && at_boundary && (ext_result_i == stop_q);
    assign load      = accept && !stop_hit;
    assign asm_clear = start_i && (state_q != CAPTURE);

    ob_chunk_assembler #(
        .ROW_W        (ROW_W),
        .DRIVER_WIDTH (DRIVER_WIDTH),
        .CHUNKS       (CHUNKS)
    ) u_asm (
        .clk_i         (clk_i),
        .rst_async_i   (rst_async_i),
        .clear_i       (asm_clear),
        .load_i        (load),
        .beat_i        (ext_result_i),
        .at_boundary_o (at_boundary),
        .row_valid_o   (row_valid),
        .row_data_o    (row_data)
    );

    always_ff @(posedge clk_i or posedge rst_async_i) begin
        if (rst_async_i) begin
            state_q    <= IDLE;
            base_q     <= '0;
            stop_q     <= '0;
            mem_cenb_o <= 1'b1;
            mem_wenb_o <= 1'b1;
            mem_addr_o <= '0;
            mem_d_o    <= '0;
            rows_o     <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            mem_cenb_o <= 1'b1;
            mem_wenb_o <= 1'b1;

            if (row_valid) begin
                mem_cenb_o <= 1'b0;
                mem_wenb_o <= 1'b0;
                // rows_o == O_SIZE has zero low bits, so the write lands back
                // on base: that reuse is what flags the overflow.
                mem_addr_o <= base_q + rows_o[AW-1:0];
                mem_d_o    <= row_data;
                if (rows_o == ROWS_MAX) begin
                    overflow_o <= 1'b1;
                end else begin
                    rows_o <= rows_o + 1'b1;
                end
            end

            unique case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        base_q     <= base_addr_i;
                        stop_q     <= stop_code_i;
                        rows_o     <= '0;
                        done_o     <= 1'b0;
                        overflow_o <= 1'b0;
                        busy_o     <= 1'b1;
                        state_q    <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (stop_hit) begin
                        busy_o  <= 1'b0;
                        done_o  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef OB_RESULT_CAPTURE_CHECKSUM_EN
    always_ff @(posedge clk_i or posedge rst_async_i) begin
        if (rst_async_i) begin
            checksum_o <= '0;
        end else if (asm_clear) begin
            checksum_o <= '0;
        end else if (row_valid) begin
            checksum_o <= checksum_o ^ row_data;
        end
    end
`endif

endmodule

// File: tb/tb_ob_result_capture.sv
// Randomised bench for ob_result_capture against a beat-list reference model.
module tb_ob_result_capture;

    localparam int O_SIZE = 256;
    localparam int DW     = 16;
    localparam int CHUNKS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  base_addr = '0;
    logic [15:0] stop_code = '0;
    logic [15:0] ext_result = '0;
    logic        ext_valid = 1'b0;
    logic        mem_cenb, mem_wenb;
    logic [7:0]  mem_addr;
    logic [63:0] mem_d;
    logic [8:0]  rows;
    logic        busy, done, overflow;
`ifdef OB_RESULT_CAPTURE_CHECKSUM_EN
    logic [63:0] checksum;
`endif

    ob_result_capture #(
        .WIDTH        (16),
        .COL          (4),
        .DRIVER_WIDTH (16),
        .O_SIZE       (256)
    ) dut (
        .clk_i        (clk),
        .rst_async_i  (rst),
        .start_i      (start),
        .base_addr_i  (base_addr),
        .stop_code_i  (stop_code),
        .ext_result_i (ext_result),
        .ext_valid_i  (ext_valid),
        .mem_cenb_o   (mem_cenb),
        .mem_wenb_o   (mem_wenb),
        .mem_addr_o   (mem_addr),
        .mem_d_o      (mem_d),
        .rows_o       (rows),
        .busy_o       (busy),
        .done_o       (done),
        .overflow_o   (overflow)
`ifdef OB_RESULT_CAPTURE_CHECKSUM_EN
        ,
        .checksum_o   (checksum)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [7:0]  addr;
        logic [63:0] data;
        int          cyc;
        logic        wenb;
    } wr_t;

    wr_t exp_q[$];
    wr_t act_q[$];

    always @(negedge clk) begin
        if (!rst && (!mem_cenb || !mem_wenb)) begin
            wr_t w;
            w.addr = mem_addr;
            w.data = mem_d;
            w.cyc  = cyc;
            w.wenb = mem_wenb | mem_cenb;
            act_q.push_back(w);
        end
    end

    // Reference model: list of beats in the current row, row count, flags.
    bit          m_cap, m_done, m_ovf;
    int          m_rows;
    logic [7:0]  m_base;
    logic [15:0] m_stop;
    logic [15:0] m_beats[$];
    logic [63:0] m_sum;

    task automatic model_reset();
        m_cap = 0; m_done = 0; m_ovf = 0; m_rows = 0;
        m_beats.delete(); m_sum = '0;
    endtask

    task automatic step(input bit st, input logic [7:0] b, input logic [15:0] sc,
                        input bit v, input logic [15:0] d);
        wr_t w;
        logic [63:0] row;
        start = st; base_addr = b; stop_code = sc; ext_valid = v; ext_result = d;
        if (!m_cap) begin
            if (st) begin
                m_cap = 1; m_base = b; m_stop = sc; m_rows = 0;
                m_done = 0; m_ovf = 0; m_beats.delete(); m_sum = '0;
            end
        end else if (v) begin
            if (m_beats.size() == 0 && d == m_stop) begin
                m_cap = 0; m_done = 1;
            end else begin
                m_beats.push_back(d);
                if (m_beats.size() == CHUNKS) begin
                    row = '0;
                    for (int k = 0; k < CHUNKS; k++) row |= 64'(m_beats[k]) << (DW * k);
                    w.addr = 8'((int'(m_base) + m_rows) % O_SIZE);
                    w.data = row;
                    w.cyc  = cyc + 1;
                    w.wenb = 1'b0;
                    exp_q.push_back(w);
                    if (m_rows == O_SIZE) m_ovf = 1;
                    else m_rows++;
                    m_sum ^= row;
                    m_beats.delete();
                end
            end
        end
        @(posedge clk); #1;
        start = 1'b0; ext_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 8'h00, 16'h0000, 0, 16'h0000);
    endtask

    task automatic beat(input logic [15:0] d);
        step(0, 8'h00, 16'h0000, 1, d);
    endtask

    task automatic arm(input logic [7:0] b, input logic [15:0] sc);
        step(1, b, sc, 0, 16'h0000);
    endtask

    task automatic compare_writes(input string tag);
        check({tag, "_nwrites"}, 64'(act_q.size()), 64'(exp_q.size()));
        while (act_q.size() > 0 && exp_q.size() > 0) begin
            wr_t a, e;
            a = act_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_addr"}, 64'(a.addr), 64'(e.addr));
            check({tag, "_data"}, a.data, e.data);
            check({tag, "_cycle"}, 64'(a.cyc), 64'(e.cyc));
            check({tag, "_wenb"}, 64'(a.wenb), 64'(e.wenb));
        end
        act_q.delete();
        exp_q.delete();
    endtask

    task automatic check_status(input string tag);
        check({tag, "_rows"}, 64'(rows), 64'(m_rows));
        check({tag, "_busy"}, 64'(busy), 64'(m_cap));
        check({tag, "_done"}, 64'(done), 64'(m_done));
        check({tag, "_ovf"}, 64'(overflow), 64'(m_ovf));
`ifdef OB_RESULT_CAPTURE_CHECKSUM_EN
        check({tag, "_csum"}, checksum, m_sum);
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cenb"}, 64'(mem_cenb), 64'd1);
        check({tag, "_wenb"}, 64'(mem_wenb), 64'd1);
        check({tag, "_addr"}, 64'(mem_addr), 64'd0);
        check({tag, "_d"}, mem_d, 64'd0);
        check({tag, "_rows"}, 64'(rows), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_ovf"}, 64'(overflow), 64'd0);
    endtask

    // Finish any partial row with random data, then send the stop code.
    task automatic close_stream();
        while (m_cap && m_beats.size() != 0) beat(16'($urandom_range(0, 16'hFFFE)));
        beat(m_stop);
        idle(2);
    endtask

    initial begin
        model_reset();
        @(posedge clk); #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        idle(1);

        // Beats in IDLE are ignored.
        for (int i = 0; i < 6; i++) beat(16'($urandom));
        idle(2);
        compare_writes("idle_beats");
        check_status("idle_beats");

        // Single row.
        arm(8'h10, 16'hFFFF);
        beat(16'h0001); beat(16'h0002); beat(16'h0003); beat(16'h0004);
        beat(16'hFFFF);
        idle(2);
        compare_writes("single");
        check_status("single");
        check("single_hold_d", mem_d, 64'h0004_0003_0002_0001);
        check("single_rows_const", 64'(rows), 64'd1);

        // Back-to-back streaming, valid held high; re-arm from DONE.
        arm(8'h10, 16'hFFFF);
        for (int i = 0; i < 32; i++) beat(16'($urandom_range(0, 16'hFFFE)));
        beat(16'hFFFF);
        idle(2);
        compare_writes("b2b");
        check_status("b2b");

        // Stop code mid-row is data.
        arm(8'h20, 16'hFFFF);
        beat(16'hAAAA); beat(16'hFFFF);
        check("midstop_done_early", 64'(done), 64'd0);
        beat(16'hBBBB); beat(16'hCCCC);
        beat(16'hFFFF);
        idle(2);
        compare_writes("midstop");
        check_status("midstop");
        check("midstop_data", mem_d, 64'hCCCC_BBBB_FFFF_AAAA);

        // Address wrap without overflow.
        arm(8'hFE, 16'h1234);
        for (int i = 0; i < 12; i++) beat(16'($urandom_range(16'h2000, 16'hFFFF)));
        close_stream();
        compare_writes("wrap3");
        check_status("wrap3");

        // 257 rows from base 0: overflow and saturation.
        arm(8'h00, 16'h0000);
        for (int i = 0; i < 257 * CHUNKS; i++) beat(16'($urandom_range(1, 16'hFFFF)));
        close_stream();
        compare_writes("ovf");
        check_status("ovf");
        check("ovf_rows_const", 64'(rows), 64'd256);

        // Toggling valid, with a start pulse during capture that must be ignored.
        arm(8'h30, 16'h5A5A);
        for (int i = 0; i < 16; i++) begin
            if (i == 5) step(1, 8'h99, 16'h0000, 1, 16'($urandom_range(0, 16'h5A00)));
            else step(0, 8'h00, 16'h0000, (i % 2) == 0, 16'($urandom_range(0, 16'h5A00)));
        end
        close_stream();
        compare_writes("gaps");
        check_status("gaps");

        // Reset mid-row: no write, reset values, then a clean capture.
        arm(8'h40, 16'hFFFF);
        beat(16'h1111); beat(16'h2222);
        rst = 1'b1;
        model_reset();
        #2;
        check_reset_outputs("midreset");
        @(posedge clk); #1;
        rst = 1'b0;
        idle(1);
        compare_writes("midreset_nowrite");
        arm(8'h55, 16'hFFFF);
        beat(16'h0A0A); beat(16'h0B0B); beat(16'h0C0C); beat(16'h0D0D);
        beat(16'hFFFF);
        idle(2);
        compare_writes("rearm");
        check_status("rearm");

        // Random captures with gaps and occasional stop codes in the stream.
        for (int r = 0; r < 4; r++) begin
            logic [15:0] sc;
            sc = 16'($urandom);
            arm(8'($urandom), sc);
            for (int i = 0; i < 40; i++)
                step(0, 8'h00, 16'h0000, $urandom_range(0, 3) != 0,
                     ($urandom_range(0, 9) == 0) ? sc : 16'($urandom));
            if (m_cap) close_stream();
            else idle(2);
            compare_writes("rand");
            check_status("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
